// File: rtl/bsg_manycore_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bsg_manycore_pkg: shared manycore types, incl. link pipe configuration.
// Revision: 1.0
// ---------------------------------------------------------------------------
package bsg_manycore_pkg;

  typedef struct packed {
    logic [31:0] stages;
    logic        bypass;
  } bsg_manycore_link_pipe_cfg_s;

endpackage
`default_nettype wire

// File: rtl/bsg_manycore_link_two_fifo_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bsg_manycore_link_two_fifo_stage: two-entry valid/ready_and FIFO stage.
// Revision: 1.0
// ---------------------------------------------------------------------------
module bsg_manycore_link_two_fifo_stage #(
  parameter int width_p = 64
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_and_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               ready_and_i,
  output logic               empty_o
);

  logic [width_p-1:0] mem_q [2];
  logic               wptr_q, wptr_d;
  logic               rptr_q, rptr_d;
  logic [1:0]         count_q, count_d;
  logic               enq, deq;

  // Handshakes are masked during reset so nothing moves while flushing.
  assign ready_and_o = (count_q != 2'd2) & ~reset_i;
  assign v_o         = (count_q != 2'd0) & ~reset_i;
  assign data_o      = mem_q[rptr_q];
  assign empty_o     = (count_q == 2'd0);

  assign enq = v_i & ready_and_o;
  assign deq = v_o & ready_and_i;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q + {1'b0, enq} - {1'b0, deq};
    if (enq) wptr_d = ~wptr_q;
    if (deq) rptr_d = ~rptr_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wptr_q] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/bsg_manycore_link_elastic_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bsg_manycore_link_elastic_pipe: per-channel elastic buffering for tile links.
// Revision: 1.0
// ---------------------------------------------------------------------------
module bsg_manycore_link_elastic_pipe
  import bsg_manycore_pkg::*;
#(
  parameter int                        width_p        = 64,
  parameter int                        num_channels_p = 12,
  parameter int                        stages_p       = 2,
  parameter logic [num_channels_p-1:0] bypass_mask_p  = '0,
  parameter int                        reset_stages_p = 2
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  output logic                              reset_o,
  input  logic [num_channels_p-1:0]         v_i,
  input  logic [num_channels_p*width_p-1:0] data_i,
  output logic [num_channels_p-1:0]         ready_and_o,
  output logic [num_channels_p-1:0]         v_o,
  output logic [num_channels_p*width_p-1:0] data_o,
  input  logic [num_channels_p-1:0]         ready_and_i,
  output logic [num_channels_p-1:0]         empty_o
);

  // Reset delay chain is intentionally never reset itself.
  logic [reset_stages_p-1:0] reset_chain_q;

  always_ff @(posedge clk_i) begin
    reset_chain_q[0] <= reset_i;
    for (int i = 1; i < reset_stages_p; i++) begin
      reset_chain_q[i] <= reset_chain_q[i-1];
    end
  end

  assign reset_o = reset_chain_q[reset_stages_p-1];

  for (genvar c = 0; c < num_channels_p; c++) begin : g_ch
    localparam bsg_manycore_link_pipe_cfg_s cfg_lp = '{stages: stages_p, bypass: bypass_mask_p[c]};
    localparam int stages_lp = int'(cfg_lp.stages);

    if (cfg_lp.bypass) begin : g_bypass
      assign v_o[c]                       = v_i[c];
      assign data_o[c*width_p +: width_p] = data_i[c*width_p +: width_p];
      assign ready_and_o[c]               = ready_and_i[c];
      assign empty_o[c]                   = 1'b1;
    end else begin : g_buf
      logic [stages_lp:0]   v_link;
      logic [stages_lp:0]   rdy_link;
      logic [width_p-1:0]   data_link [stages_lp+1];
      logic [stages_lp-1:0] stage_empty;

      assign v_link[0]    = v_i[c];
      assign data_link[0] = data_i[c*width_p +: width_p];
      assign ready_and_o[c]      = rdy_link[0];
      assign rdy_link[stages_lp] = ready_and_i[c];

      for (genvar s = 0; s < stages_lp; s++) begin : g_stage
        bsg_manycore_link_two_fifo_stage #(
          .width_p(width_p)
        ) u_stage (
          .clk_i      (clk_i),
          .reset_i    (reset_i),
          .v_i        (v_link[s]),
          .data_i     (data_link[s]),
          .ready_and_o(rdy_link[s]),
          .v_o        (v_link[s+1]),
          .data_o     (data_link[s+1]),
          .ready_and_i(rdy_link[s+1]),
          .empty_o    (stage_empty[s])
        );
      end

      assign v_o[c]                       = v_link[stages_lp];
      assign data_o[c*width_p +: width_p] = data_link[stages_lp];
      assign empty_o[c]                   = (&stage_empty) | reset_i;
    end
  end

endmodule
`default_nettype wire
